// File: rtl/decoder_3x8_pulse_if.sv
// decoder_3x8_pulse_if
// Code/strobe bundle between an event source (master) and decoder_3x8_pulse (slave).
//   a       : 3-bit encoded line index, qualified by valid
//   valid   : code on a is valid
//   ready   : decoder can accept a code this cycle
//   d       : one-hot decoded strobe bus
//   busy    : pulse or gap in progress
//   overrun : sticky flag, valid seen while not ready (optional feature)
//   ovr_clr : synchronous clear for overrun
interface decoder_3x8_pulse_if;
    logic [2:0] a;
    logic       valid;
    logic       ready;
    logic [7:0] d;
    logic       busy;
    logic       overrun;
    logic       ovr_clr;

    modport master (
        output a, valid, ovr_clr,
        input  ready, d, busy, overrun
    );

    modport slave (
        input  a, valid, ovr_clr,
        output ready, d, busy, overrun
    );
endinterface

// File: rtl/decoder_3x8_pulse.sv
// decoder_3x8_pulse
// Sequential 3-to-8 decoder. Accepts a code on a valid/ready handshake, drives the
// matching one-hot line of d for PULSE_LEN cycles, then forces GAP_LEN cycles of
// all-zero output before the next code can be accepted.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : decoder_3x8_pulse_if.slave (a, valid, ready, d, busy, overrun, ovr_clr)
//
// Optional feature macro: DECODER_OVERRUN_DETECT_EN
//   defined   : overrun sets on an edge with valid=1 and ready=0, cleared by ovr_clr
//               (clear wins over set)
//   undefined : overrun tied to 0, ovr_clr ignored
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | d=0, ready=1, waiting for valid
// PULSE | d=1<<code, counter runs down the pulse length
// GAP   | d=0, counter runs down the forced idle gap
module decoder_3x8_pulse #(
    parameter int CNT_W     = 8,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_3x8_pulse_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counter is loaded with length-1 so that terminal count (0) is the last cycle.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       d_q, d_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            d_q   <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            d_q   <= d_nxt;
        end
    end

    // d is the registered decode of the latched code, so it doubles as the code latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        d_nxt     = d_q;
        unique case (state)
            IDLE: begin
                d_nxt = 8'h00;
                if (bus.valid) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LOAD;
                    d_nxt     = 8'h01 << bus.a;
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    d_nxt = 8'h00;
                    if (GAP_LEN > 0) begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                d_nxt = 8'h00;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                d_nxt     = 8'h00;
            end
        endcase
    end

    // Handshake outputs come from the state register only.
    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE);
    assign bus.d     = d_q;

`ifdef DECODER_OVERRUN_DETECT_EN
    logic ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (bus.ovr_clr) begin
            ovr_q <= 1'b0;
        end else if (bus.valid && (state != IDLE)) begin
            ovr_q <= 1'b1;
        end
    end

    assign bus.overrun = ovr_q;
`else
    logic unused_ovr_clr;

    assign unused_ovr_clr = bus.ovr_clr;
    assign bus.overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
module tb_decoder_3x8_pulse;

    localparam int P0 = 4;
    localparam int G0 = 2;
    localparam int P1 = 1;
    localparam int G1 = 0;

`ifdef DECODER_OVERRUN_DETECT_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic       vld [2];
    logic [2:0] av  [2];
    logic       clr [2];

    int total = 0;
    int bad   = 0;

    decoder_3x8_pulse_if if0 ();
    decoder_3x8_pulse_if if1 ();

    assign if0.valid   = vld[0];
    assign if0.a       = av[0];
    assign if0.ovr_clr = clr[0];
    assign if1.valid   = vld[1];
    assign if1.a       = av[1];
    assign if1.ovr_clr = clr[1];

    decoder_3x8_pulse #(.CNT_W(8), .PULSE_LEN(P0), .GAP_LEN(G0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );

    decoder_3x8_pulse #(.CNT_W(8), .PULSE_LEN(P1), .GAP_LEN(G1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycles elapsed since the accepting edge decide the phase.
    bit         m_idle [2];
    int         m_el   [2];
    logic [2:0] m_code [2];
    bit         m_ovr  [2];

    function automatic int pl(int k);
        return (k == 0) ? P0 : P1;
    endfunction

    function automatic int gl(int k);
        return (k == 0) ? G0 : G1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit was_idle;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_idle[k] = 1'b1;
                m_el[k]   = 0;
                m_code[k] = 3'd0;
                m_ovr[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                was_idle = m_idle[k];
                if (OVR_ON) begin
                    if (clr[k]) m_ovr[k] = 1'b0;
                    else if (vld[k] && !was_idle) m_ovr[k] = 1'b1;
                end
                if (was_idle) begin
                    if (vld[k]) begin
                        m_idle[k] = 1'b0;
                        m_code[k] = av[k];
                        m_el[k]   = 1;
                    end
                end else begin
                    m_el[k] = m_el[k] + 1;
                    if (m_el[k] > pl(k) + gl(k)) m_idle[k] = 1'b1;
                end
            end
        end
    end

    function automatic logic [7:0] exp_d(int k);
        if (m_idle[k] || m_el[k] > pl(k)) return 8'h00;
        return 8'h01 << m_code[k];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0;
            av[k]  = 3'($urandom);
            clr[k] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        drive_idle();
        while (!(m_idle[0] && m_idle[1]) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!(m_idle[0] && m_idle[1])) begin
            bad++;
            $display("FAIL wait_idle model not idle after %0d cycles (want idle within 20)", n);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #12;
        total++;
        if (if0.d !== 8'h00 || if0.ready !== 1'b1 || if0.busy !== 1'b0 || if0.overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got d=%h r=%b b=%b o=%b want d=00 r=1 b=0 o=0",
                     if0.d, if0.ready, if0.busy, if0.overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                logic [7:0] dd;
                logic rr, bb, oo;
                dd = (k == 0) ? if0.d : if1.d;
                rr = (k == 0) ? if0.ready : if1.ready;
                bb = (k == 0) ? if0.busy : if1.busy;
                oo = (k == 0) ? if0.overrun : if1.overrun;
                total++;
                if (dd !== 8'h00 || rr !== 1'b1 || bb !== 1'b0 || oo !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_idle dut%0d c=%0d got d=%h r=%b b=%b o=%b want d=00 r=1 b=0 o=0",
                             k, c, dd, rr, bb, oo);
                end
            end
        end
    endtask

    task automatic test_single();
        int width;
        int gap;
        bit seen_ready;
        wait_idle();
        vld[0] = 1'b1;
        av[0]  = 3'd5;
        tick();
        vld[0] = 1'b0;
        width = 0;
        gap = 0;
        seen_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (if0.d !== exp_d(0) || if0.busy !== !m_idle[0] || if0.ready !== m_idle[0]) begin
                bad++;
                $display("FAIL single c=%0d got d=%h b=%b r=%b want d=%h b=%b r=%b",
                         c, if0.d, if0.busy, if0.ready, exp_d(0), !m_idle[0], m_idle[0]);
            end
            if (if0.d === 8'h20) width++;
            else if (if0.busy === 1'b1 && !seen_ready) gap++;
            if (if0.ready === 1'b1) seen_ready = 1'b1;
            av[0] = 3'($urandom);
            tick();
        end
        total++;
        if (width != 4) begin
            bad++;
            $display("FAIL single_width got %0d want 4", width);
        end
        total++;
        if (gap != 2) begin
            bad++;
            $display("FAIL single_gap got %0d want 2", gap);
        end
    endtask

    task automatic test_sweep();
        int idx;
        int starts [$];
        logic [7:0] vals [$];
        logic [7:0] prev;
        wait_idle();
        idx = 0;
        prev = 8'h00;
        for (int c = 0; c < 64; c++) begin
            if (m_idle[0]) begin
                if (idx < 8) begin
                    vld[0] = 1'b1;
                    av[0]  = 3'(idx);
                    idx++;
                end else begin
                    vld[0] = 1'b0;
                end
            end else begin
                av[0] = 3'($urandom);
            end
            tick();
            total++;
            if (if0.d !== exp_d(0) || if0.overrun !== m_ovr[0]) begin
                bad++;
                $display("FAIL sweep c=%0d got d=%h o=%b want d=%h o=%b",
                         c, if0.d, if0.overrun, exp_d(0), m_ovr[0]);
            end
            if (if0.d !== 8'h00 && prev === 8'h00) begin
                starts.push_back(c);
                vals.push_back(if0.d);
            end
            prev = if0.d;
        end
        total++;
        if (vals.size() != 8) begin
            bad++;
            $display("FAIL sweep_count got %0d pulses want 8", vals.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                logic [7:0] want;
                want = 8'h01 << i;
                total++;
                if (vals[i] !== want) begin
                    bad++;
                    $display("FAIL sweep_val i=%0d got %h want %h", i, vals[i], want);
                end
                if (i > 0) begin
                    total++;
                    if (starts[i] - starts[i-1] != 7) begin
                        bad++;
                        $display("FAIL sweep_period i=%0d got %0d want 7", i, starts[i] - starts[i-1]);
                    end
                end
            end
        end
        vld[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        wait_idle();
        vld[0] = 1'b1;
        av[0]  = 3'd7;
        tick();
        vld[0] = 1'b0;
        total++;
        if (if0.d !== 8'h80) begin
            bad++;
            $display("FAIL mid_pulse1 got %h want 80", if0.d);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (if0.d !== 8'h00 || if0.ready !== 1'b1 || if0.busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got d=%h r=%b b=%b want d=00 r=1 b=0", if0.d, if0.ready, if0.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vld[0] = 1'b1;
        av[0]  = 3'd2;
        tick();
        vld[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            total++;
            if (if0.d !== exp_d(0) || if0.ready !== m_idle[0]) begin
                bad++;
                $display("FAIL post_reset c=%0d got d=%h r=%b want d=%h r=%b",
                         c, if0.d, if0.ready, exp_d(0), m_idle[0]);
            end
            tick();
        end
    endtask

    task automatic test_overrun();
        wait_idle();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        vld[0] = 1'b1;
        av[0]  = 3'($urandom);
        tick();
        total++;
        if (if0.overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_accept got %b want 0", if0.overrun);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (if0.overrun !== OVR_ON) begin
                bad++;
                $display("FAIL ovr_set c=%0d got %b want %b", c, if0.overrun, OVR_ON);
            end
        end
        clr[0] = 1'b1;
        total++;
        if (if0.ready !== 1'b0) begin
            bad++;
            $display("FAIL ovr_busy got ready=%b want 0", if0.ready);
        end
        tick();
        clr[0] = 1'b0;
        vld[0] = 1'b0;
        total++;
        if (if0.overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_clr got %b want 0", if0.overrun);
        end
    endtask

    task automatic test_short();
        int pulses;
        wait_idle();
        pulses = 0;
        vld[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            av[1] = 3'($urandom);
            tick();
            total++;
            if (if1.d !== exp_d(1) || if1.ready !== m_idle[1] || $countones(if1.d) > 1) begin
                bad++;
                $display("FAIL short c=%0d got d=%h r=%b want d=%h r=%b",
                         c, if1.d, if1.ready, exp_d(1), m_idle[1]);
            end
            if (if1.d !== 8'h00) pulses++;
        end
        vld[1] = 1'b0;
        total++;
        if (pulses != 10) begin
            bad++;
            $display("FAIL short_rate got %0d pulses want 10", pulses);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            for (int k = 0; k < 2; k++) begin
                vld[k] = ($urandom_range(0, 3) != 0);
                av[k]  = 3'($urandom);
                clr[k] = ($urandom_range(0, 7) == 0);
            end
            tick();
            total++;
            if (if0.d !== exp_d(0) || if0.busy !== !m_idle[0] || if0.overrun !== m_ovr[0]
                || $countones(if0.d) > 1) begin
                bad++;
                $display("FAIL rand0 c=%0d got d=%h b=%b o=%b want d=%h b=%b o=%b",
                         c, if0.d, if0.busy, if0.overrun, exp_d(0), !m_idle[0], m_ovr[0]);
            end
            total++;
            if (if1.d !== exp_d(1) || if1.busy !== !m_idle[1] || if1.overrun !== m_ovr[1]
                || $countones(if1.d) > 1) begin
                bad++;
                $display("FAIL rand1 c=%0d got d=%h b=%b o=%b want d=%h b=%b o=%b",
                         c, if1.d, if1.busy, if1.overrun, exp_d(1), !m_idle[1], m_ovr[1]);
            end
        end
        drive_idle();
    endtask

    initial begin
        rst_n = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_sweep();
        test_reset_mid();
        test_overrun();
        test_short();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_3x8_pulse.md
Name: decoder_3x8_pulse

Overview:
- Sequential 3-to-8 decoder; the receive end of the 8-to-3 priority encoder's (a, valid) code interface.
- Accepts a 3-bit code with a valid/ready handshake.
- Drives the matching one-hot line of an 8-bit bus for a programmable pulse length, then forces a programmable idle gap before accepting the next code.
- Used to turn encoded event indices back into timed strobe lines.

Parameters:
- CNT_W, 8, width of the internal pulse/gap down-counter.
- PULSE_LEN, 4, cycles the one-hot output stays asserted. Legal range 1 .. 2^CNT_W-1.
- GAP_LEN, 2, cycles of all-zero output forced after each pulse. Legal range 0 .. 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- a  input  3  encoded line index; sampled only on accept.
- valid  input  1  code on a is valid.
- ready  output  1  block can accept a code this cycle.
- d  output  8  one-hot decoded output, registered.
- busy  output  1  pulse or gap in progress.
- overrun  output  1  sticky overrun flag (see Optional Feature).
- ovr_clr  input  1  synchronous clear for overrun.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state IDLE, counter 0, d=8'h00.
  - ready=1, busy=0, overrun=0.
  - Takes effect immediately even mid-pulse; d drops to 0 without waiting for a clock.
- FSM states:
  - IDLE: d=0, ready=1, busy=0.
  - PULSE: d = 1<<a_latched, ready=0, busy=1.
  - GAP: d=0, ready=0, busy=1.
- ready and busy are decoded from the state register only; no combinational path from valid or a.
- Accept: rising edge with state IDLE and valid=1.
  - Latch a; next state PULSE; counter loads PULSE_LEN-1.
  - d shows the decoded one-hot value starting the cycle after the accept edge (latency 1).
- PULSE:
  - counter!=0: decrement; d held.
  - counter==0 and GAP_LEN>0: go to GAP, counter loads GAP_LEN-1, d cleared.
  - counter==0 and GAP_LEN==0: go directly to IDLE, d cleared.
- GAP:
  - counter!=0: decrement.
  - counter==0: go to IDLE.
- Pulse width is exactly PULSE_LEN cycles. Zero time is exactly GAP_LEN cycles plus at least one IDLE cycle.
- With valid held high continuously, one code is accepted every PULSE_LEN+GAP_LEN+1 cycles.
- Changes on a or valid while not IDLE are ignored. No queuing; the code presented at the next IDLE edge is accepted.
- Exactly one bit of d is high in PULSE; d is all-zero in IDLE and GAP. Never two bits high.
- Every code 0..7 is legal. a=0 decodes to d=8'h01; there is no "no-code" case because valid qualifies the input.

Optional Feature:
- Macro: DECODER_OVERRUN_DETECT_EN.
- Defined:
  - overrun sets on any rising edge with valid=1 and ready=0.
  - Stays set until an edge with ovr_clr=1; clear wins over a simultaneous set.
  - Does not affect FSM operation.
- Undefined:
  - overrun tied to 0; ovr_clr ignored.
  - No extra flops synthesized.

Test Plan (PULSE_LEN=4, GAP_LEN=2):
- Reset, then hold valid=0 for 5 cycles -> d=8'h00, ready=1, busy=0, overrun=0 throughout.
- Single accept a=3'd5, valid=1 for one cycle -> d=8'h20 exactly 4 cycles starting 1 cycle after accept; then 2 cycles of 8'h00 with busy=1; then ready=1.
- Sweep a=0..7 with valid held high -> d walks 8'h01, 8'h02 ... 8'h80, one value every 7 cycles. Change a mid-pulse -> no effect on d.
- Assert rst_n=0 during the 2nd cycle of a pulse on a=3'd7 -> d=8'h00 and ready=1 immediately. After release, a new code is accepted normally.
- Macro defined: valid=1 while busy -> overrun=1 next edge and stays 1. Pulse ovr_clr with valid=1 and ready=0 in the same cycle -> overrun=0.
- Rebuild with GAP_LEN=0 and PULSE_LEN=1 -> one-cycle pulses; continuous valid gives one accept every 2 cycles; d never has more than one bit set.
